scarv_cop_mem_arb: RTL and testbench
====================================

Name: scarv_cop_mem_arb

Overview:
- Two-port arbiter sharing one word-addressed data memory bus between the host core load/store port (port 0, host_*) and the coprocessor load/store port (port 1, cop_*).
- Both requesters and the bus use the same cen/wen/addr/wdata/ben/rdata/stall/error protocol, so each requester sees an ordinary private memory.
- Sits between the core/coprocessor memory units and the memory interconnect.
- One transaction is outstanding on the bus at a time. Back-to-back issue is supported.

Parameters:
- TIMEOUT, 255: number of consecutive bus stall cycles after which the pending transaction is aborted with an error. 0 disables the timeout.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- host_mem_cen, host_mem_wen  in  1  host request and write flag
- host_mem_addr, host_mem_wdata  in  32  host address (word aligned) and write data
- host_mem_ben  in  4  host byte enables
- host_mem_rdata  out  32  host read data
- host_mem_stall, host_mem_error  out  1  host stall and error
- cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben  in  1/1/32/32/4  coprocessor request, same meaning as host
- cop_mem_rdata, cop_mem_stall, cop_mem_error  out  32/1/1  coprocessor response, same meaning as host
- bus_mem_cen, bus_mem_wen, bus_mem_addr, bus_mem_wdata, bus_mem_ben  out  1/1/32/32/4  shared bus request
- bus_mem_rdata, bus_mem_stall, bus_mem_error  in  32/1/1  shared bus response

Behaviour:
- Protocol, all three interfaces:
  - A request is presented in a cycle with cen=1.
  - Its response cycle is the first later cycle with stall=0; rdata and error are valid only in that cycle.
  - The requester holds all request signals while stall=1.
  - cen=1 in a response cycle is a new request (back-to-back).
- Registered state:
  - pend: bus transaction outstanding.
  - owner: port that owns pend.
  - wait0, wait1: each port is expecting a response.
  - rr_last: last granted port.
  - tcnt: timeout counter.
- bus_resp = pend && !bus_mem_stall. resp_i = bus_resp && owner==i, or a timeout abort for owner i.
- bus_free = !pend || bus_resp.
- Grant happens in a cycle with bus_free, among ports with cen=1.
  - Without the optional macro: port 0 (host) wins ties.
  - Next state: pend=1, owner=winner.
  - With bus_free and no cen: pend=0.
- Bus request muxing:
  - In a grant cycle the bus request outputs are the winner's inputs.
  - While pend && bus_mem_stall they are the owner's inputs; the owner is holding them.
  - Otherwise all bus request outputs are 0. bus_mem_addr=0 whenever bus_mem_cen=0.
- waiti_next = cen_i || (waiti && !resp_i).
- Requester response outputs:
  - cop_/host_mem_stall_i = waiti && !resp_i.
  - rdata_i = resp_i ? bus_mem_rdata : 0.
  - error_i = resp_i && (bus_mem_error || abort).
- The non-owner never sees a response. A request from it that is not granted sees stall=1 from the next cycle until it is granted and completed.
- Timeout (TIMEOUT>0):
  - tcnt increments each cycle with pend && bus_mem_stall, and clears otherwise.
  - Abort happens in the cycle where tcnt==TIMEOUT-1 and bus_mem_stall=1. That cycle is forced into a response cycle for the owner: error=1, rdata=0, stall=0.
  - In the abort cycle: bus_mem_cen=0, no grant, pend cleared, tcnt cleared.
- Reset:
  - While g_resetn=0, all outputs are 0 (including stalls and bus_mem_cen).
  - State resets to pend=0, owner=0, wait0=wait1=0, rr_last=1, tcnt=0.
  - Reset mid-transaction abandons it with no response to the requester.
- Simultaneous events: in a response cycle, the completing port and the other port may both request; the arbitration rule applies to both.

Optional Feature:
- SCARV_COP_MEM_ARB_RR_EN
- Defined: round-robin arbitration. On a tie the port != rr_last wins. rr_last updates on every grant.
- Undefined: fixed priority, host over cop. rr_last is unused.

Test Plan:
- Host read only:
  - Stimulus: host_mem_cen=1, addr=0x100 in cycle N; bus_mem_stall=0 and bus_mem_rdata=0xDEADBEEF in N+1.
  - Required: bus_mem_addr=0x100 in N; host_mem_rdata=0xDEADBEEF and host_mem_stall=0 in N+1; cop outputs stay 0.
- Simultaneous requests, macro off:
  - Stimulus: host addr 0x10 and cop addr 0x20 in cycle N, both held.
  - Required: bus_mem_addr=0x10 in N; in N+1 host response, cop_mem_stall=1, bus_mem_addr=0x20; cop response in N+2.
- Round-robin, macro on:
  - Stimulus: both ports issue continuous back-to-back requests for 4 transactions.
  - Required: grant order host, cop, host, cop.
- Bus stall:
  - Stimulus: cop owns pend; bus_mem_stall=1 for 3 cycles; host requests meanwhile.
  - Required: cop_mem_stall=1 for 3 cycles; bus outputs stable at cop values; host stalled, granted in the cop response cycle.
- Error and timeout:
  - Stimulus 1: bus_mem_error=1 in a host response cycle. Required: host_mem_error=1, cop_mem_error=0.
  - Stimulus 2: TIMEOUT=4, bus_mem_stall held high. Required: owner error=1 and stall=0 on the 4th stall cycle, bus_mem_cen=0 that cycle, then the other pending port is granted.
- Reset mid-pend:
  - Stimulus: g_resetn=0 for one cycle while pend=1.
  - Required: all outputs 0 during reset; after reset, pend=0 and a fresh host request is granted immediately.

Source files
------------

// File: rtl/scarv_cop_mem_arb.sv
// Two-port arbiter sharing one word-addressed data memory bus between the host (port 0)
// and the coprocessor (port 1). Define SCARV_COP_MEM_ARB_RR_EN for round-robin ties.
module scarv_cop_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        host_mem_cen,
    input  logic        host_mem_wen,
    input  logic [31:0] host_mem_addr,
    input  logic [31:0] host_mem_wdata,
    input  logic [3:0]  host_mem_ben,
    output logic [31:0] host_mem_rdata,
    output logic        host_mem_stall,
    output logic        host_mem_error,

    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    input  logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_rdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,

    output logic        bus_mem_cen,
    output logic        bus_mem_wen,
    output logic [31:0] bus_mem_addr,
    output logic [31:0] bus_mem_wdata,
    output logic [3:0]  bus_mem_ben,
    input  logic [31:0] bus_mem_rdata,
    input  logic        bus_mem_stall,
    input  logic        bus_mem_error
);

    localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic          pend_q, pend_d;
    logic          owner_q, owner_d;   // 0 = host, 1 = cop
    logic          wait0_q, wait0_d;
    logic          wait1_q, wait1_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
`ifdef SCARV_COP_MEM_ARB_RR_EN
    logic          rr_last_q, rr_last_d;
`endif

    logic bus_resp, bus_free, abort, resp0, resp1;
    logic grant, winner, bus_hold, sel, sel_cen;

    assign bus_resp = pend_q && !bus_mem_stall;
    assign bus_free = !pend_q || bus_resp;
    assign abort    = (TIMEOUT != 0) && pend_q && bus_mem_stall && (tcnt_q == TLAST);
    assign resp0    = (bus_resp || abort) && !owner_q;
    assign resp1    = (bus_resp || abort) &&  owner_q;

    assign grant = bus_free && (host_mem_cen || cop_mem_cen);
`ifdef SCARV_COP_MEM_ARB_RR_EN
    assign winner = (host_mem_cen && cop_mem_cen) ? !rr_last_q : !host_mem_cen;
`else
    assign winner = !host_mem_cen;
`endif

    // A stalled owner is holding its request, so its inputs are replayed onto the bus.
    assign bus_hold = pend_q && bus_mem_stall && !abort;
    assign sel      = grant ? winner : owner_q;
    assign sel_cen  = sel ? cop_mem_cen : host_mem_cen;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        bus_mem_cen   = 1'b0;
        bus_mem_wen   = 1'b0;
        bus_mem_addr  = 32'h0;
        bus_mem_wdata = 32'h0;
        bus_mem_ben   = 4'h0;
        if (g_resetn && (grant || bus_hold) && sel_cen) begin
            bus_mem_cen   = 1'b1;
            bus_mem_wen   = sel ? cop_mem_wen   : host_mem_wen;
            bus_mem_addr  = sel ? cop_mem_addr  : host_mem_addr;
            bus_mem_wdata = sel ? cop_mem_wdata : host_mem_wdata;
            bus_mem_ben   = sel ? cop_mem_ben   : host_mem_ben;
        end
    end

    assign host_mem_stall = g_resetn && wait0_q && !resp0;
    assign host_mem_error = g_resetn && resp0 && (bus_mem_error || abort);
    assign host_mem_rdata = (g_resetn && resp0 && !abort) ? bus_mem_rdata : 32'h0;

    assign cop_mem_stall  = g_resetn && wait1_q && !resp1;
    assign cop_mem_error  = g_resetn && resp1 && (bus_mem_error || abort);
    assign cop_mem_rdata  = (g_resetn && resp1 && !abort) ? bus_mem_rdata : 32'h0;

    always_comb begin
        pend_d  = pend_q;
        owner_d = owner_q;
        if (abort) begin
            pend_d = 1'b0;
        end else if (grant) begin
            pend_d  = 1'b1;
            owner_d = winner;
        end else if (bus_free) begin
            pend_d = 1'b0;
        end
        wait0_d = host_mem_cen || (wait0_q && !resp0);
        wait1_d = cop_mem_cen  || (wait1_q && !resp1);
        tcnt_d  = ((TIMEOUT != 0) && bus_hold) ? tcnt_q + 1'b1 : '0;
`ifdef SCARV_COP_MEM_ARB_RR_EN
        rr_last_d = grant ? winner : rr_last_q;
`endif
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            pend_q    <= 1'b0;
            owner_q   <= 1'b0;
            wait0_q   <= 1'b0;
            wait1_q   <= 1'b0;
            tcnt_q    <= '0;
`ifdef SCARV_COP_MEM_ARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            pend_q    <= pend_d;
            owner_q   <= owner_d;
            wait0_q   <= wait0_d;
            wait1_q   <= wait1_d;
            tcnt_q    <= tcnt_d;
`ifdef SCARV_COP_MEM_ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Bench for scarv_cop_mem_arb: directed vector table, a grant-order sequence and
// randomized traffic from protocol-following requesters against a transaction model.
module tb_scarv_cop_mem_arb;

    localparam int TOUT = 4;
`ifdef SCARV_COP_MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        cen;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
    } req_t;

    typedef struct {
        logic        rn;
        logic        hc;
        logic [31:0] ha;
        logic        cc;
        logic [31:0] ca;
        logic        bs;
        logic [31:0] br;
        logic        be;
        logic        e_bc;
        logic [31:0] e_ba;
        logic        e_hs;
        logic [31:0] e_hr;
        logic        e_he;
        logic        e_cs;
        logic [31:0] e_cr;
        logic        e_ce;
    } vec_t;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    req_t        rq [2];
    logic        host_mem_cen, host_mem_wen, cop_mem_cen, cop_mem_wen;
    logic [31:0] host_mem_addr, host_mem_wdata, cop_mem_addr, cop_mem_wdata;
    logic [3:0]  host_mem_ben, cop_mem_ben;
    logic [31:0] host_mem_rdata, cop_mem_rdata, bus_mem_rdata;
    logic        host_mem_stall, host_mem_error, cop_mem_stall, cop_mem_error;
    logic        bus_mem_cen, bus_mem_wen, bus_mem_stall, bus_mem_error;
    logic [31:0] bus_mem_addr, bus_mem_wdata;
    logic [3:0]  bus_mem_ben;

    int n_pass;
    int n_total;

    assign host_mem_cen   = rq[0].cen;
    assign host_mem_wen   = rq[0].wen;
    assign host_mem_addr  = rq[0].addr;
    assign host_mem_wdata = rq[0].wdata;
    assign host_mem_ben   = rq[0].ben;
    assign cop_mem_cen    = rq[1].cen;
    assign cop_mem_wen    = rq[1].wen;
    assign cop_mem_addr   = rq[1].addr;
    assign cop_mem_wdata  = rq[1].wdata;
    assign cop_mem_ben    = rq[1].ben;

    always #5 g_clk = ~g_clk;

    scarv_cop_mem_arb #(.TIMEOUT(TOUT)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .host_mem_cen(host_mem_cen), .host_mem_wen(host_mem_wen),
        .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
        .host_mem_ben(host_mem_ben), .host_mem_rdata(host_mem_rdata),
        .host_mem_stall(host_mem_stall), .host_mem_error(host_mem_error),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
        .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
        .bus_mem_cen(bus_mem_cen), .bus_mem_wen(bus_mem_wen),
        .bus_mem_addr(bus_mem_addr), .bus_mem_wdata(bus_mem_wdata),
        .bus_mem_ben(bus_mem_ben), .bus_mem_rdata(bus_mem_rdata),
        .bus_mem_stall(bus_mem_stall), .bus_mem_error(bus_mem_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    // Reference model: which port holds the bus (-1 when idle), which ports are
    // owed an answer, and how many bus stall cycles the current transfer has seen.
    int   m_owner;
    bit   m_want [2];
    int   m_stall_run;
    int   m_last;
    int   m_answered;
    bit   m_abort;
    req_t        e_bus;
    logic        e_stall [2];
    logic [31:0] e_rdata [2];
    logic        e_err   [2];

    task automatic m_reset();
        m_owner     = -1;
        m_want[0]   = 1'b0;
        m_want[1]   = 1'b0;
        m_stall_run = 0;
        m_last      = 1;
    endtask

    task automatic m_observe(input bit bstall);
        m_abort    = (m_owner >= 0) && bstall && (m_stall_run + 1 == TOUT);
        m_answered = ((m_owner >= 0) && (!bstall || m_abort)) ? m_owner : -1;
    endtask

    task automatic m_cycle(input bit rn, input bit bstall, input logic [31:0] brd, input bit berr);
        int  win;
        bit  done;
        win  = -1;
        done = (m_answered >= 0) && !m_abort;
        e_bus = '0;
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 1'b0;
            e_rdata[i] = 32'h0;
            e_err[i]   = 1'b0;
        end
        if (!rn) begin
            m_reset();
            return;
        end
        if ((m_owner < 0 || done) && (rq[0].cen || rq[1].cen)) begin
            if (rq[0].cen && rq[1].cen) win = RR_EN ? 1 - m_last : 0;
            else win = rq[0].cen ? 0 : 1;
        end
        if (win >= 0) e_bus = rq[win];
        else if (m_owner >= 0 && bstall && !m_abort) e_bus = rq[m_owner];
        if (!e_bus.cen) e_bus = '0;
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = m_want[i] && (m_answered != i);
            e_rdata[i] = (m_answered == i && !m_abort) ? brd : 32'h0;
            e_err[i]   = (m_answered == i) && (berr || m_abort);
            m_want[i]  = rq[i].cen || (m_want[i] && (m_answered != i));
        end
        if (m_owner >= 0 && bstall && !m_abort) m_stall_run++;
        else m_stall_run = 0;
        if (win >= 0) begin
            m_owner = win;
            m_last  = win;
        end else if (m_answered >= 0) begin
            m_owner = -1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bus_cen"},    32'(bus_mem_cen),    32'(e_bus.cen));
        check({tag, ".bus_wen"},    32'(bus_mem_wen),    32'(e_bus.wen));
        check({tag, ".bus_addr"},   bus_mem_addr,        e_bus.addr);
        check({tag, ".bus_wdata"},  bus_mem_wdata,       e_bus.wdata);
        check({tag, ".bus_ben"},    32'(bus_mem_ben),    32'(e_bus.ben));
        check({tag, ".host_stall"}, 32'(host_mem_stall), 32'(e_stall[0]));
        check({tag, ".host_rdata"}, host_mem_rdata,      e_rdata[0]);
        check({tag, ".host_error"}, 32'(host_mem_error), 32'(e_err[0]));
        check({tag, ".cop_stall"},  32'(cop_mem_stall),  32'(e_stall[1]));
        check({tag, ".cop_rdata"},  cop_mem_rdata,       e_rdata[1]);
        check({tag, ".cop_error"},  32'(cop_mem_error),  32'(e_err[1]));
    endtask

    vec_t vq [$];

    task automatic add_vec(input int rn, input int hc, input logic [31:0] ha,
                           input int cc, input logic [31:0] ca, input int bs,
                           input logic [31:0] br, input int be,
                           input int ebc, input logic [31:0] eba, input int ehs,
                           input logic [31:0] ehr, input int ehe, input int ecs,
                           input logic [31:0] ecr, input int ece);
        vec_t v;
        v.rn = (rn != 0); v.hc = (hc != 0); v.ha = ha; v.cc = (cc != 0); v.ca = ca;
        v.bs = (bs != 0); v.br = br; v.be = (be != 0);
        v.e_bc = (ebc != 0); v.e_ba = eba; v.e_hs = (ehs != 0); v.e_hr = ehr;
        v.e_he = (ehe != 0); v.e_cs = (ecs != 0); v.e_cr = ecr; v.e_ce = (ece != 0);
        vq.push_back(v);
    endtask

    initial begin
        vec_t v;
        logic [31:0] exp_addr;
        bit hold;
        n_pass = 0;
        n_total = 0;
        g_resetn = 1'b0;
        rq[0] = '0;
        rq[1] = '0;
        bus_mem_stall = 1'b0;
        bus_mem_rdata = 32'h0;
        bus_mem_error = 1'b0;

        //      rn hc ha      cc ca      bs br            be | bc ba      hs hr            he cs cr            ce
        add_vec(0, 1, 'h100, 1, 'h20,   0, 0,            0,   0, 0,      0, 0,            0, 0, 0,            0);
        add_vec(1, 0, 0,     0, 0,      0, 0,            0,   0, 0,      0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h100, 0, 0,      0, 0,            0,   1, 'h100,  0, 0,            0, 0, 0,            0);
        add_vec(1, 0, 0,     0, 0,      0, 'hDEADBEEF,   0,   0, 0,      0, 'hDEADBEEF,   0, 0, 0,            0);
        add_vec(0, 0, 0,     0, 0,      0, 0,            0,   0, 0,      0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h10,  1, 'h20,   0, 0,            0,   1, 'h10,   0, 0,            0, 0, 0,            0);
        add_vec(1, 0, 0,     1, 'h20,   0, 'h11111111,   0,   1, 'h20,   0, 'h11111111,   0, 1, 0,            0);
        add_vec(1, 0, 0,     0, 0,      0, 'h22222222,   0,   0, 0,      0, 0,            0, 0, 'h22222222,   0);
        add_vec(1, 0, 0,     1, 'h30,   0, 0,            0,   1, 'h30,   0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h40,  1, 'h30,   1, 0,            0,   1, 'h30,   0, 0,            0, 1, 0,            0);
        add_vec(1, 1, 'h40,  1, 'h30,   1, 0,            0,   1, 'h30,   1, 0,            0, 1, 0,            0);
        add_vec(1, 1, 'h40,  1, 'h30,   1, 0,            0,   1, 'h30,   1, 0,            0, 1, 0,            0);
        add_vec(1, 1, 'h40,  0, 0,      0, 'h33333333,   0,   1, 'h40,   1, 0,            0, 0, 'h33333333,   0);
        add_vec(1, 0, 0,     0, 0,      0, 'h44444444,   1,   0, 0,      0, 'h44444444,   1, 0, 0,            0);
        add_vec(0, 0, 0,     0, 0,      0, 0,            0,   0, 0,      0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h50,  1, 'h60,   0, 0,            0,   1, 'h50,   0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h50,  1, 'h60,   1, 0,            0,   1, 'h50,   1, 0,            0, 1, 0,            0);
        add_vec(1, 1, 'h50,  1, 'h60,   1, 0,            0,   1, 'h50,   1, 0,            0, 1, 0,            0);
        add_vec(1, 1, 'h50,  1, 'h60,   1, 0,            0,   1, 'h50,   1, 0,            0, 1, 0,            0);
        add_vec(1, 0, 0,     1, 'h60,   1, 'h55555555,   0,   0, 0,      0, 0,            1, 1, 0,            0);
        add_vec(1, 0, 0,     1, 'h60,   0, 0,            0,   1, 'h60,   0, 0,            0, 1, 0,            0);
        add_vec(0, 1, 'h70,  1, 'h60,   0, 'h66666666,   0,   0, 0,      0, 0,            0, 0, 0,            0);
        add_vec(1, 1, 'h70,  0, 0,      1, 0,            0,   1, 'h70,   0, 0,            0, 0, 0,            0);
        add_vec(1, 0, 0,     0, 0,      0, 'h77777777,   0,   0, 0,      0, 'h77777777,   0, 0, 0,            0);

        @(posedge g_clk); #1;
        foreach (vq[k]) begin
            v = vq[k];
            g_resetn      = v.rn;
            rq[0]         = '{v.hc, 1'b0, v.ha, 32'h0, 4'hf};
            rq[1]         = '{v.cc, 1'b0, v.ca, 32'h0, 4'hf};
            bus_mem_stall = v.bs;
            bus_mem_rdata = v.br;
            bus_mem_error = v.be;
            #2;
            check($sformatf("v%0d.bus_cen", k),    32'(bus_mem_cen),    32'(v.e_bc));
            check($sformatf("v%0d.bus_addr", k),   bus_mem_addr,        v.e_ba);
            check($sformatf("v%0d.host_stall", k), 32'(host_mem_stall), 32'(v.e_hs));
            check($sformatf("v%0d.host_rdata", k), host_mem_rdata,      v.e_hr);
            check($sformatf("v%0d.host_error", k), 32'(host_mem_error), 32'(v.e_he));
            check($sformatf("v%0d.cop_stall", k),  32'(cop_mem_stall),  32'(v.e_cs));
            check($sformatf("v%0d.cop_rdata", k),  cop_mem_rdata,       v.e_cr);
            check($sformatf("v%0d.cop_error", k),  32'(cop_mem_error),  32'(v.e_ce));
            @(posedge g_clk); #1;
        end

        // Both ports saturate the bus: grant order shows the tie-break policy.
        g_resetn = 1'b0;
        rq[0] = '0;
        rq[1] = '0;
        bus_mem_stall = 1'b0;
        bus_mem_error = 1'b0;
        @(posedge g_clk); #1;
        for (int k = 0; k < 4; k++) begin
            g_resetn = 1'b1;
            rq[0] = '{1'b1, 1'b0, 32'h1000, 32'h0, 4'hf};
            rq[1] = '{1'b1, 1'b0, 32'h2000, 32'h0, 4'hf};
            #2;
            exp_addr = (RR_EN && (k % 2 == 1)) ? 32'h2000 : 32'h1000;
            check($sformatf("grant%0d.bus_cen", k), 32'(bus_mem_cen), 32'h1);
            check($sformatf("grant%0d.bus_addr", k), bus_mem_addr, exp_addr);
            @(posedge g_clk); #1;
        end

        // Randomized traffic; requesters hold while the model says they are stalled.
        g_resetn = 1'b0;
        rq[0] = '0;
        rq[1] = '0;
        m_reset();
        @(posedge g_clk); #1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            g_resetn      = ($urandom_range(99) != 0);
            bus_mem_stall = ($urandom_range(9) < 4);
            bus_mem_rdata = $urandom();
            bus_mem_error = ($urandom_range(9) == 0);
            m_observe(bus_mem_stall);
            for (int i = 0; i < 2; i++) begin
                hold = g_resetn && m_want[i] && (m_answered != i);
                if (!hold) begin
                    rq[i].cen   = ($urandom_range(1) == 1);
                    rq[i].wen   = ($urandom_range(1) == 1);
                    rq[i].addr  = $urandom() & 32'hFFFF_FFFC;
                    rq[i].wdata = $urandom();
                    rq[i].ben   = 4'($urandom());
                end
            end
            #2;
            m_cycle(g_resetn, bus_mem_stall, bus_mem_rdata, bus_mem_error);
            check_all($sformatf("r%0d", cyc));
            @(posedge g_clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
